// File: rtl/ext_arb_pkg.sv
// Shared types and widths for the external bus master arbiter.
// State encoding is fixed so the debug state output can be decoded by checkers.
package ext_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ADDR_W = 30;
  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ext_arb_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr_i,
// wrapping modulo NUM_REQ, returned as one-hot grant and binary index.
module ext_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = IDX_W'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_master_arbiter.sv
// Round-robin arbiter sharing the external bus master bridge among NUM_REQ requesters,
// one transaction in flight. Define EXT_ARB_TIMEOUT_EN to build the ack timeout/abort path.
module ext_master_arbiter
  import ext_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*BE_W-1:0]   req_be,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         bus_address,
  output logic [BE_W-1:0]           bus_be,
  output logic                      bus_read,
  output logic                      bus_write,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic                      bus_ack,
  input  logic [DATA_W-1:0]         bus_rdata,
  output logic [1:0]                dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                grant_now;
  logic                timeout_hit;
  logic                err_flag;

  ext_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign grant_now = (state_q == ST_IDLE) && pick_any;

`ifdef EXT_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Ack wins over an abort landing in the same cycle.
  assign timeout_hit = (state_q == ST_BUS) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign err_flag    = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (grant_now) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (state_q == ST_BUS && !bus_ack) begin
      if (timeout_hit) err_d = 1'b1;
      else             cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_flag    = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_BUS;
      ST_BUS:  if (bus_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Strobes decode from state so an async reset drops them at once.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    bus_read  = (state_q == ST_BUS) && !wr_q;
    bus_write = (state_q == ST_BUS) && wr_q;
    done      = '0;
    err       = '0;
    if (state_q == ST_DONE) begin
      done = gnt_q;
      if (err_flag) err = gnt_q;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    if (grant_now) begin
      gnt_d   = pick_grant;
      addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
      be_d    = req_be[pick_idx*BE_W +: BE_W];
      wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
      wr_d    = req_wr[pick_idx];
      ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
    if (state_q == ST_BUS) begin
      if (bus_ack) begin
        if (!wr_q) rdata_d = bus_rdata;
      end else if (timeout_hit) begin
        rdata_d = TIMEOUT_RDATA;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_address = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign rdata       = rdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ext_master_arbiter.sv
// Self-checking bench for ext_master_arbiter: bus responder, scoreboard of expected
// transactions in grant order, monitor comparing bus fields and completions.
`timescale 1ns/1ps
module tb_ext_master_arbiter;
  import ext_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TO_CYC  = 16;

  typedef struct packed {
    logic        err;
    logic        wr;
    logic [1:0]  idx;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  len;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req, req_wr;
  logic [NUM_REQ*30-1:0]     req_addr;
  logic [NUM_REQ*4-1:0]      req_be;
  logic [NUM_REQ*32-1:0]     req_wdata;
  logic [NUM_REQ-1:0]        done, err;
  logic [31:0]               rdata, bus_wdata, bus_rdata;
  logic                      busy, bus_read, bus_write, bus_ack;
  logic [29:0]               bus_address;
  logic [3:0]                bus_be;
  logic [1:0]                dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] model_rdata;

  logic resp_en, resp_ack, stray_ack;
  int   ack_delay, strobe_seen, strobe_len;
  exp_t mon_e;

  assign bus_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  ext_master_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_be      (req_be),
    .req_wdata   (req_wdata),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .busy        (busy),
    .bus_address (bus_address),
    .bus_be      (bus_be),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [29:0] a);
    return (a == 30'h100) ? 32'h1234_5678 : ({a, 2'b00} ^ 32'hC3C3_0F0F);
  endfunction

  // Bus responder: ack after ack_delay extra strobe cycles; random data otherwise.
  initial begin
    resp_ack    = 1'b0;
    bus_rdata   = '0;
    strobe_seen = 0;
    forever begin
      @(negedge clk);
      if ((bus_read || bus_write) && !reset) begin
        strobe_seen++;
        if (resp_en && strobe_seen == ack_delay + 1) begin
          resp_ack  = 1'b1;
          bus_rdata = bus_read ? rd_val(bus_address) : $urandom;
        end else begin
          resp_ack  = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        strobe_seen = 0;
        resp_ack    = 1'b0;
        bus_rdata   = $urandom;
      end
    end
  end

  // Monitor / scoreboard
  initial strobe_len = 0;
  always @(negedge clk) begin
    if (reset) begin
      strobe_len = 0;
    end else begin
      if (bus_read || bus_write) begin
        strobe_len++;
        check("one_strobe", {31'd0, bus_read & bus_write}, 32'd0);
        check("busy_in_bus", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", exp_q.size(), 32'd1);
        end else begin
          mon_e = exp_q[0];
          check("bus_address", {2'b00, bus_address}, {2'b00, mon_e.addr});
          check("bus_be", {28'd0, bus_be}, {28'd0, mon_e.be});
          check("bus_write", {31'd0, bus_write}, {31'd0, mon_e.wr});
          if (mon_e.wr) check("bus_wdata", bus_wdata, mon_e.wdata);
        end
      end
      if (err != 0 && done == 0) check("err_without_done", {28'd0, err}, 32'd0);
      if (done != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {28'd0, done}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_vec", {28'd0, done}, 32'd1 << mon_e.idx);
          check("err_vec", {28'd0, err}, mon_e.err ? (32'd1 << mon_e.idx) : 32'd0);
          check("rdata", rdata, mon_e.rdata);
          check("strobe_len", strobe_len, {24'd0, mon_e.len});
          check("no_strobe_in_done", {31'd0, bus_read | bus_write}, 32'd0);
          check("busy_in_done", {31'd0, busy}, 32'd1);
          check("state_done", {30'd0, dbg_state}, 32'd2);
        end
        strobe_len = 0;
      end
    end
  end

  task automatic set_req(input int idx, input logic wr, input logic [29:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    req_wr[idx]            = wr;
    req_addr[idx*30 +: 30] = a;
    req_be[idx*4 +: 4]     = be;
    req_wdata[idx*32 +: 32] = wd;
  endtask

  task automatic push_exp(input int idx, input logic wr, input logic [29:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int len, input logic abort);
    exp_t e;
    if (abort)    model_rdata = TIMEOUT_RDATA;
    else if (!wr) model_rdata = rd_val(a);
    e.err   = abort;
    e.wr    = wr;
    e.idx   = 2'(idx);
    e.addr  = a;
    e.be    = be;
    e.wdata = wd;
    e.rdata = model_rdata;
    e.len   = 8'(len);
    exp_q.push_back(e);
  endtask

  // Waits for n completions; at the final done cycle drops the requests in drop_mask.
  task automatic wait_dones(input int n, input int budget, input logic [NUM_REQ-1:0] drop_mask);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done != 0) got++;
    end
    req = req & ~drop_mask;
    check("done_count", got, n);
  endtask

  task automatic run_single(input int idx, input logic wr, input logic [29:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input int len);
    set_req(idx, wr, a, be, wd);
    push_exp(idx, wr, a, be, wd, len, 1'b0);
    req[idx] = 1'b1;
    @(negedge clk);
    check("strobe_latency", {31'd0, bus_read | bus_write}, 32'd1);
    wait_dones(1, 60, NUM_REQ'(1) << idx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    model_rdata = '0;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset     = 1'b1;
    req       = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    resp_en   = 1'b1;
    ack_delay = 2;
    stray_ack = 1'b0;
    model_rdata = '0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_done", {28'd0, done}, 32'd0);
    check("rst_err", {28'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    check("rst_address", {2'b00, bus_address}, 32'd0);
    check("rst_be", {28'd0, bus_be}, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single read, ack on third strobe cycle
    run_single(0, 1'b0, 30'h100, 4'hF, 32'h0, 3);
    @(negedge clk);
    check("t1_rdata_hold", rdata, 32'h1234_5678);

    // write keeps previous rdata
    run_single(2, 1'b1, 30'h3FFF_FFFC, 4'h3, 32'hA5A5_5A5A, 3);
    @(negedge clk);
    check("t2_rdata_hold", rdata, 32'h1234_5678);

    // requester drops req mid-transaction
    ack_delay = 3;
    set_req(3, 1'b0, 30'h0ABC, 4'hC, 32'h0);
    push_exp(3, 1'b0, 30'h0ABC, 4'hC, 32'h0, 4, 1'b0);
    req[3] = 1'b1;
    @(negedge clk);
    check("t6_strobe_latency", {31'd0, bus_read}, 32'd1);
    @(negedge clk);
    req[3] = 1'b0;
    wait_dones(1, 60, '0);

    // stray ack in IDLE
    repeat (2) @(negedge clk);
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_busy", {31'd0, busy}, 32'd0);
      check("stray_strobes", {30'd0, bus_read, bus_write}, 32'd0);
      check("stray_rdata", rdata, model_rdata);
      check("stray_state", {30'd0, dbg_state}, 32'd0);
    end
    stray_ack = 1'b0;

    // contention from a fresh pointer: grant order 0,1,2,3,0
    do_reset();
    ack_delay = 0;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 1'(i % 2), 30'h2000 + 30'(i * 16), 4'(i + 1), 32'h1111_1111 * (i + 1));
    for (int k = 0; k < 5; k++) begin
      int i;
      i = k % NUM_REQ;
      push_exp(i, 1'(i % 2), 30'h2000 + 30'(i * 16), 4'(i + 1), 32'h1111_1111 * (i + 1), 1, 1'b0);
    end
    req = 4'b1111;
    wait_dones(5, 100, 4'b1111);
    repeat (3) @(negedge clk);

    // reset mid-BUS, then next grant comes from pointer 0
    ack_delay = 5;
    set_req(2, 1'b0, 30'h3000, 4'hF, 32'h0);
    push_exp(2, 1'b0, 30'h3000, 4'hF, 32'h0, 6, 1'b0);
    req = 4'b0100;
    cyc = 0;
    while (!bus_read && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_strobe_seen", {31'd0, bus_read}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t4_read_dropped", {31'd0, bus_read}, 32'd0);
    check("t4_busy_dropped", {31'd0, busy}, 32'd0);
    exp_q.delete();
    model_rdata = '0;
    req = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_no_done", {28'd0, done}, 32'd0);
    end
    reset = 1'b0;
    ack_delay = 1;
    set_req(1, 1'b0, 30'h3100, 4'h5, 32'h0);
    set_req(3, 1'b0, 30'h3300, 4'hA, 32'h0);
    push_exp(1, 1'b0, 30'h3100, 4'h5, 32'h0, 2, 1'b0);
    req = 4'b1010;
    wait_dones(1, 60, 4'b1010);
    repeat (2) @(negedge clk);

`ifdef EXT_ARB_TIMEOUT_EN
    // no ack: abort after TO_CYC strobe cycles; late ack ignored
    resp_en = 1'b0;
    set_req(1, 1'b0, 30'h0440, 4'hF, 32'h0);
    push_exp(1, 1'b0, 30'h0440, 4'hF, 32'h0, TO_CYC, 1'b1);
    req = 4'b0010;
    wait_dones(1, TO_CYC + 20, 4'b0010);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("t5_late_ack_busy", {31'd0, busy}, 32'd0);
    check("t5_late_ack_rdata", rdata, 32'hDEAD_BEEF);
    check("t5_late_ack_err", {28'd0, err}, 32'd0);
    @(negedge clk);
    check("t5_idle_state", {30'd0, dbg_state}, 32'd0);
    resp_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
